// File: rtl/dv_seq.sv
// rtl/dv_seq.sv - sequential restoring divider, 2*DW-bit dividend by DW-bit divisor
module dv_seq #(
  parameter int DW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2*DW-1:0] i_dvdnd_val,
  input  logic [DW-1:0]   i_dvsr_val,
  output logic [2*DW-1:0] o_quotient,
  output logic [DW-1:0]   o_remainder,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_div_zero
);

  localparam int CW = $clog2(2*DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [2*DW-1:0] dvd;
  logic [2*DW-1:0] quo;
  logic [DW-1:0]   dvsr;
  logic [DW:0]     rem;
  logic [CW-1:0]   cnt;
  logic [DW:0]     shifted;
  logic [DW+1:0]   trial;
  logic            last;

  // One extra bit on the trial difference acts as the sign of the subtraction
  always_comb begin
    shifted = {rem[DW-1:0], dvd[2*DW-1]};
    trial   = {1'b0, shifted} - {2'b00, dvsr};
    last    = (cnt == CW'(2*DW-1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = (i_dvsr_val == '0) ? DONE : CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      dvd         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      rem         <= '0;
      cnt         <= '0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_ready     <= 1'b0;
      o_div_zero  <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            dvd  <= i_dvdnd_val;
            dvsr <= i_dvsr_val;
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          dvd <= dvd << 1;
          cnt <= cnt + 1'b1;
          if (!trial[DW+1]) begin
            rem <= trial[DW:0];
            quo <= {quo[2*DW-2:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[2*DW-2:0], 1'b0};
          end
        end
        DONE: begin
          o_ready <= 1'b1;
          // A zero divisor skips CALC, so dvd still holds the untouched dividend
          if (dvsr == '0) begin
            o_quotient  <= '1;
            o_remainder <= dvd[DW-1:0];
            o_div_zero  <= 1'b1;
          end else begin
            o_quotient  <= quo;
            o_remainder <= rem[DW-1:0];
            o_div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dv_seq.sv
// tb/tb_dv_seq.sv - directed self-checking bench for dv_seq
module tb_dv_seq;

  localparam int DW = 8;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_start;
  logic [2*DW-1:0] i_dvdnd_val;
  logic [DW-1:0]   i_dvsr_val;
  logic [2*DW-1:0] o_quotient;
  logic [DW-1:0]   o_remainder;
  logic            o_ready;
  logic            o_busy;
  logic            o_div_zero;

  int checks = 0;
  int errors = 0;

  dv_seq #(.DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_dvdnd_val (i_dvdnd_val),
    .i_dvsr_val  (i_dvsr_val),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_ready     (o_ready),
    .o_busy      (o_busy),
    .o_div_zero  (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances at least one edge, stops once o_ready is seen or the budget runs out
  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(posedge i_clk); #1;
      cnt++;
    end while (!o_ready && cnt < 40);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez,
                         input int lat);
    int cnt;
    @(negedge i_clk);
    i_dvdnd_val = a;
    i_dvsr_val  = b;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start     = 1'b0;
    i_dvdnd_val = 16'hA5C3;
    i_dvsr_val  = 8'h03;
    cnt = 0;
    while (!o_ready && cnt < 40) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    check({tag, " latency"}, cnt, lat);
    check({tag, " quotient"}, o_quotient, eq);
    check({tag, " remainder"}, o_remainder, er);
    check({tag, " div_zero"}, o_div_zero, ez);
    @(posedge i_clk); #1;
    check({tag, " ready_pulse"}, o_ready, 1'b0);
    check({tag, " idle_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    int  cnt;
    logic busy_ok;
    logic seen;

    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_dvdnd_val = '0;
    i_dvsr_val  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst quotient", o_quotient, 16'h0);
    check("rst remainder", o_remainder, 8'h0);
    check("rst ready", o_ready, 1'b0);
    check("rst busy", o_busy, 1'b0);
    check("rst div_zero", o_div_zero, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;

    run_div("15/5", 16'd15, 8'd5, 16'd3, 8'd0, 1'b0, 17);
    run_div("240/12", 16'd240, 8'd12, 16'd20, 8'd0, 1'b0, 17);
    run_div("3200/100", 16'd3200, 8'd100, 16'd32, 8'd0, 1'b0, 17);
    run_div("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
    run_div("65535/1", 16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 17);
    run_div("65535/255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
    run_div("100/200", 16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 17);
    run_div("1234/0", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1);
    run_div("9/2", 16'd9, 8'd2, 16'd4, 8'd1, 1'b0, 17);

    // Start during CALC is ignored, busy held through DONE
    @(negedge i_clk);
    i_dvdnd_val = 16'd1000;
    i_dvsr_val  = 8'd7;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("ign busy_at_start", o_busy, 1'b1);
    cnt     = 0;
    busy_ok = 1'b1;
    while (!o_ready && cnt < 40) begin
      @(posedge i_clk); #1;
      cnt++;
      if (cnt == 4) begin
        i_dvdnd_val = 16'd50;
        i_dvsr_val  = 8'd5;
        i_start     = 1'b1;
      end
      if (cnt == 5) i_start = 1'b0;
      if (!o_ready && !o_busy) busy_ok = 1'b0;
    end
    check("ign latency", cnt, 17);
    check("ign quotient", o_quotient, 16'd142);
    check("ign remainder", o_remainder, 8'd6);
    check("ign busy_held", busy_ok, 1'b1);

    // Reset in the middle of CALC
    @(negedge i_clk);
    i_dvdnd_val = 16'd1000;
    i_dvsr_val  = 8'd7;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (8) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("arst quotient", o_quotient, 16'h0);
    check("arst remainder", o_remainder, 8'h0);
    check("arst busy", o_busy, 1'b0);
    check("arst ready", o_ready, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen  = 1'b0;
    repeat (20) begin
      @(posedge i_clk); #1;
      if (o_ready) seen = 1'b1;
    end
    check("arst no_ready", seen, 1'b0);
    run_div("post_rst 15/5", 16'd15, 8'd5, 16'd3, 8'd0, 1'b0, 17);

    // Start held high restarts on the first IDLE edge after DONE
    @(negedge i_clk);
    i_dvdnd_val = 16'd240;
    i_dvsr_val  = 8'd12;
    i_start     = 1'b1;
    @(posedge i_clk); #1;
    wait_ready(cnt);
    check("hold first_latency", cnt, 17);
    wait_ready(cnt);
    i_start = 1'b0;
    check("hold second_latency", cnt, 18);
    check("hold quotient", o_quotient, 16'd20);
    repeat (3) @(posedge i_clk);
    #1;
    check("hold settled_busy", o_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
